// File: rtl/lsu_split_gpio.sv
// -----------------------------------------------------------------------------
// lsu_split_gpio
//   Load/store unit. It accepts one load or store at a time over a valid/ready
//   handshake, drives a synchronous byte-enabled data RAM and a small
//   memory-mapped GPIO block, and returns a response that is held until it is
//   accepted.
//   A RAM access that crosses a word boundary is split into two RAM beats when
//   ALLOW_MISALIGNED is nonzero. Otherwise it returns an error.
//   Unmapped or illegal accesses return resp_err with no side effects.
//
// Ports
//   clk, reset_n            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready     request handshake (req_ready high only when idle)
//   req_we, req_funct3      store flag, access size/sign (000 B, 001 H, 010 W,
//                           100 BU, 101 HU)
//   req_addr, req_wdata     byte address, right-aligned store data
//   resp_valid/resp_ready   response handshake
//   resp_rdata, resp_err    extended load data (0 for stores/errors), error flag
//   mem_en/we/be/waddr/wdata  RAM request, active only in the beat states
//   mem_rdata               RAM read data, valid the cycle after a read beat
//   gpio_out                output registers, channel 0 in the LSBs
//   gpio_in                 asynchronous inputs, channel 0 in the LSBs
// -----------------------------------------------------------------------------
module lsu_split_gpio #(
    parameter int unsigned ADDR_WIDTH       = 12,
    parameter int unsigned MEM_BYTES        = 4096,
    parameter int unsigned GPIO_BASE        = 'hEF0,
    parameter int unsigned NUM_GPIO_OUT     = 2,
    parameter int unsigned NUM_GPIO_IN      = 2,
    parameter int unsigned ALLOW_MISALIGNED = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [2:0]                req_funct3,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [31:0]               req_wdata,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [31:0]               resp_rdata,
    output logic                      resp_err,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [3:0]                mem_be,
    output logic [ADDR_WIDTH-3:0]     mem_waddr,
    output logic [31:0]               mem_wdata,
    input  logic [31:0]               mem_rdata,
    output logic [32*NUM_GPIO_OUT-1:0] gpio_out,
    input  logic [32*NUM_GPIO_IN-1:0]  gpio_in
);

    localparam int unsigned GPIO_CH = NUM_GPIO_OUT + NUM_GPIO_IN;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_BEAT0,
        S_BEAT1,
        S_RDWAIT,
        S_RESP
    } state_t;

    state_t state_reg, state_next;

    // Captured request
    logic                  we_reg;
    logic [2:0]            funct3_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [31:0]           wdata_reg;

    // Response and load assembly
    logic [31:0] rdata0_reg;
    logic [31:0] resp_rdata_reg;
    logic        resp_err_reg;

    // GPIO state
    logic [NUM_GPIO_OUT-1:0][31:0] out_bank;
    logic [NUM_GPIO_IN-1:0][31:0]  in_sync1_reg;
    logic [NUM_GPIO_IN-1:0][31:0]  in_sync2_reg;

    // Decode signals (derived from the captured request)
    logic [3:0]            size;
    logic [3:0]            mask;
    logic                  f3_legal;
    logic [1:0]            off;
    logic                  crossing;
    logic [31:0]           addr_u;
    logic [31:0]           last_byte;
    logic [31:0]           gpio_idx;
    logic                  in_gpio;
    logic                  in_ram;
    logic                  ram_oob;
    logic                  gpio_err;
    logic                  misaligned_err;
    logic                  dec_err;
    logic                  gpio_store;
    logic [7:0]            lanes;
    logic [63:0]           wdata_sh;
    logic [ADDR_WIDTH-3:0] word0;
    logic [ADDR_WIDTH-3:0] word1;
    logic [31:0]           gpio_rd;
    logic [63:0]           rd_pair;
    logic [31:0]           rd_raw;
    logic [31:0]           load_result;

    // ------------------------------------------------------------------
    // Request classification
    // ------------------------------------------------------------------
    always_comb begin
        size     = 4'd4;
        mask     = 4'b1111;
        f3_legal = 1'b1;
        case (funct3_reg)
            3'b000, 3'b100: begin
                size = 4'd1;
                mask = 4'b0001;
            end
            3'b001, 3'b101: begin
                size = 4'd2;
                mask = 4'b0011;
            end
            3'b010: begin
                size = 4'd4;
                mask = 4'b1111;
            end
            default: f3_legal = 1'b0;
        endcase
    end

    assign off            = addr_reg[1:0];
    assign crossing       = ({2'b00, off} + size) > 4'd4;
    assign addr_u         = 32'(addr_reg);
    assign last_byte      = addr_u + 32'(size) - 32'd1;
    assign in_gpio        = (addr_u >= GPIO_BASE) && (addr_u < GPIO_BASE + 4 * GPIO_CH);
    assign gpio_idx       = (addr_u - GPIO_BASE) >> 2;
    assign in_ram         = addr_u < MEM_BYTES;
    assign ram_oob        = last_byte >= MEM_BYTES;
    assign gpio_err       = (off != 2'd0) || (size != 4'd4);
    assign misaligned_err = crossing && (ALLOW_MISALIGNED == 0);

    // GPIO decode takes priority over RAM, so the RAM checks only apply
    // outside the GPIO window.
    assign dec_err = !f3_legal ||
                     (in_gpio ? gpio_err : (!in_ram || ram_oob || misaligned_err));

    assign gpio_store = (state_reg == S_DECODE) && !dec_err && in_gpio && we_reg;

    // Lane mask and data shifted across a two-word window. The low half
    // belongs to beat 0 and the high half to beat 1.
    assign lanes    = 8'({4'b0000, mask} << off);
    assign wdata_sh = {32'd0, wdata_reg} << {off, 3'b000};
    assign word0    = addr_reg[ADDR_WIDTH-1:2];
    assign word1    = word0 + (ADDR_WIDTH-2)'(1);

    // ------------------------------------------------------------------
    // GPIO read mux
    // ------------------------------------------------------------------
    always_comb begin
        gpio_rd = 32'd0;
        for (int i = 0; i < int'(NUM_GPIO_OUT); i++) begin
            if (gpio_idx == 32'(i)) gpio_rd = out_bank[i];
        end
        for (int j = 0; j < int'(NUM_GPIO_IN); j++) begin
            if (gpio_idx == 32'(int'(NUM_GPIO_OUT) + j)) gpio_rd = in_sync2_reg[j];
        end
    end

    // ------------------------------------------------------------------
    // Load data assembly. In RDWAIT, mem_rdata holds the last beat. For a
    // split load, beat 0 was already captured in rdata0_reg.
    // ------------------------------------------------------------------
    assign rd_pair = crossing ? {mem_rdata, rdata0_reg} : {32'd0, mem_rdata};
    assign rd_raw  = 32'(rd_pair >> {off, 3'b000});

    always_comb begin
        load_result = rd_raw;
        case (funct3_reg)
            3'b000:  load_result = {{24{rd_raw[7]}}, rd_raw[7:0]};
            3'b001:  load_result = {{16{rd_raw[15]}}, rd_raw[15:0]};
            3'b100:  load_result = {24'd0, rd_raw[7:0]};
            3'b101:  load_result = {16'd0, rd_raw[15:0]};
            default: load_result = rd_raw;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_be     = 4'b0000;
        mem_waddr  = word0;
        mem_wdata  = 32'd0;
        case (state_reg)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = S_DECODE;
            end
            S_DECODE: begin
                // Errors and GPIO accesses complete without touching RAM.
                if (dec_err || in_gpio) state_next = S_RESP;
                else                    state_next = S_BEAT0;
            end
            S_BEAT0: begin
                mem_en    = 1'b1;
                mem_we    = we_reg;
                mem_be    = lanes[3:0];
                mem_waddr = word0;
                mem_wdata = wdata_sh[31:0];
                if (crossing)    state_next = S_BEAT1;
                else if (we_reg) state_next = S_RESP;
                else             state_next = S_RDWAIT;
            end
            S_BEAT1: begin
                mem_en    = 1'b1;
                mem_we    = we_reg;
                mem_be    = lanes[7:4];
                mem_waddr = word1;
                mem_wdata = wdata_sh[63:32];
                if (we_reg) state_next = S_RESP;
                else        state_next = S_RDWAIT;
            end
            S_RDWAIT: begin
                state_next = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture and response data
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_reg         <= 1'b0;
            funct3_reg     <= 3'd0;
            addr_reg       <= '0;
            wdata_reg      <= 32'd0;
            rdata0_reg     <= 32'd0;
            resp_rdata_reg <= 32'd0;
            resp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (req_valid) begin
                        we_reg     <= req_we;
                        funct3_reg <= req_funct3;
                        addr_reg   <= req_addr;
                        wdata_reg  <= req_wdata;
                    end
                end
                S_DECODE: begin
                    resp_err_reg   <= dec_err;
                    resp_rdata_reg <= (!dec_err && in_gpio && !we_reg) ? gpio_rd : 32'd0;
                end
                S_BEAT1: begin
                    // Beat-0 read data is on mem_rdata during beat 1.
                    if (!we_reg) rdata0_reg <= mem_rdata;
                end
                S_RDWAIT: begin
                    resp_rdata_reg <= load_result;
                end
                default: ;
            endcase
        end
    end

    assign resp_rdata = resp_rdata_reg;
    assign resp_err   = resp_err_reg;

    // ------------------------------------------------------------------
    // GPIO output registers. They are written at the edge that leaves DECODE.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < int'(NUM_GPIO_OUT); gi++) begin : g_gpio_out
        logic [31:0] chan_reg;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                chan_reg <= 32'd0;
            end else if (gpio_store && (gpio_idx == 32'(gi))) begin
                chan_reg <= wdata_reg;
            end
        end

        assign out_bank[gi] = chan_reg;
    end

    assign gpio_out = out_bank;

    // ------------------------------------------------------------------
    // Two-flop synchronisers for the asynchronous GPIO inputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_sync1_reg <= '0;
            in_sync2_reg <= '0;
        end else begin
            in_sync1_reg <= gpio_in;
            in_sync2_reg <= in_sync1_reg;
        end
    end

endmodule

// File: tb/tb_lsu_split_gpio.sv
module tb_lsu_split_gpio;

    localparam int AW = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          req_valid;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          resp_ready;
    logic [31:0]   mem_rdata;
    logic [63:0]   gpio_in;

    logic          req_ready, resp_valid, resp_err, mem_en, mem_we;
    logic [31:0]   resp_rdata, mem_wdata;
    logic [3:0]    mem_be;
    logic [AW-3:0] mem_waddr;
    logic [63:0]   gpio_out;

    // Second instance built with misaligned accesses disallowed
    logic          req_ready_b, resp_valid_b, resp_err_b, mem_en_b, mem_we_b;
    logic [31:0]   resp_rdata_b, mem_wdata_b;
    logic [3:0]    mem_be_b;
    logic [AW-3:0] mem_waddr_b;
    logic [63:0]   gpio_out_b;

    lsu_split_gpio dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .gpio_out(gpio_out), .gpio_in(gpio_in)
    );

    lsu_split_gpio #(.ALLOW_MISALIGNED(0)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready_b), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid_b), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata_b), .resp_err(resp_err_b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_be(mem_be_b),
        .mem_waddr(mem_waddr_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata),
        .gpio_out(gpio_out_b), .gpio_in(gpio_in)
    );

    // Synchronous byte-enabled RAM behind the main instance
    logic [31:0] ram [1024];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int k = 0; k < 4; k++) begin
                    if (mem_be[k]) ram[mem_waddr][8*k +: 8] <= mem_wdata[8*k +: 8];
                end
            end else begin
                mem_rdata <= ram[mem_waddr];
            end
        end
    end

    // Beat log for both instances
    int          beat_total = 0;
    int          beat_total_b = 0;
    logic [AW-3:0] log_addr [64];
    logic [3:0]  log_be [64];
    logic [31:0] log_wd [64];
    logic        log_we [64];
    always @(negedge clk) begin
        if (mem_en) begin
            log_addr[beat_total % 64] = mem_waddr;
            log_be[beat_total % 64]   = mem_be;
            log_wd[beat_total % 64]   = mem_wdata;
            log_we[beat_total % 64]   = mem_we;
            beat_total++;
        end
        if (mem_en_b) beat_total_b++;
    end

    int checks = 0;
    int failures = 0;
    int last_lat;
    logic [31:0] last_rdata;
    logic        last_err;
    logic [31:0] last_rdata_b;
    logic        last_err_b;

    // Issue one request and wait for its response. The response is not
    // consumed here. Latency counts clock edges from the accept edge through
    // the edge that raises resp_valid, both inclusive.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [AW-1:0] addr,
                          input logic [31:0] wd);
        int n;
        @(negedge clk);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        last_lat = 1;
        while (!resp_valid && last_lat < 20) begin @(posedge clk); #1; last_lat++; end
        checks++;
        if (resp_valid !== 1'b1) begin
            failures++;
            $display("FAIL resp_timeout addr=%h actual=%b required=1", addr, resp_valid);
        end
        last_rdata = resp_rdata; last_err = resp_err;
        last_rdata_b = resp_rdata_b; last_err_b = resp_err_b;
    endtask

    task automatic finish_resp;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready actual=%b required=1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rst_resp_valid actual=%b required=0", resp_valid); end
        checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL rst_resp_err actual=%b required=0", resp_err); end
        checks++; if (resp_rdata !== 32'd0) begin failures++; $display("FAIL rst_resp_rdata actual=%h required=0", resp_rdata); end
        checks++; if ({mem_en, mem_we, mem_be} !== 6'd0) begin failures++; $display("FAIL rst_mem actual=%b required=000000", {mem_en, mem_we, mem_be}); end
        checks++; if (gpio_out !== 64'd0) begin failures++; $display("FAIL rst_gpio_out actual=%h required=0", gpio_out); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_aligned_word;
        int b0;
        b0 = beat_total;
        do_req(1'b1, 3'b010, 12'h010, 32'hDEADBEEF);
        checks++; if (last_lat != 3) begin failures++; $display("FAIL sw_latency actual=%0d required=3", last_lat); end
        checks++; if (last_err !== 1'b0 || last_rdata !== 32'd0) begin failures++; $display("FAIL sw_resp actual=%b/%h required=0/0", last_err, last_rdata); end
        checks++; if (beat_total - b0 != 1) begin failures++; $display("FAIL sw_beats actual=%0d required=1", beat_total - b0); end
        checks++; if ({log_we[b0 % 64], log_be[b0 % 64], log_addr[b0 % 64], log_wd[b0 % 64]} !== {1'b1, 4'b1111, 10'h004, 32'hDEADBEEF})
            begin failures++; $display("FAIL sw_beat0 actual=%b/%b/%h/%h required=1/1111/004/deadbeef", log_we[b0 % 64], log_be[b0 % 64], log_addr[b0 % 64], log_wd[b0 % 64]); end
        finish_resp();
        b0 = beat_total;
        do_req(1'b0, 3'b010, 12'h010, 32'd0);
        checks++; if (last_lat != 4) begin failures++; $display("FAIL lw_latency actual=%0d required=4", last_lat); end
        checks++; if (last_rdata !== 32'hDEADBEEF || last_err !== 1'b0) begin failures++; $display("FAIL lw_rdata actual=%h/%b required=deadbeef/0", last_rdata, last_err); end
        checks++; if ({log_we[b0 % 64], log_be[b0 % 64], log_addr[b0 % 64]} !== {1'b0, 4'b1111, 10'h004})
            begin failures++; $display("FAIL lw_beat0 actual=%b/%b/%h required=0/1111/004", log_we[b0 % 64], log_be[b0 % 64], log_addr[b0 % 64]); end
        finish_resp();
    endtask

    task automatic test_byte_half;
        int b0;
        b0 = beat_total;
        do_req(1'b1, 3'b000, 12'h013, 32'h00000080);
        checks++; if ({log_be[b0 % 64], log_addr[b0 % 64], log_wd[b0 % 64]} !== {4'b1000, 10'h004, 32'h80000000})
            begin failures++; $display("FAIL sb_beat actual=%b/%h/%h required=1000/004/80000000", log_be[b0 % 64], log_addr[b0 % 64], log_wd[b0 % 64]); end
        finish_resp();
        b0 = beat_total;
        do_req(1'b0, 3'b000, 12'h013, 32'd0);
        checks++; if (last_rdata !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_rdata actual=%h required=ffffff80", last_rdata); end
        checks++; if (log_be[b0 % 64] !== 4'b1000) begin failures++; $display("FAIL lb_be actual=%b required=1000", log_be[b0 % 64]); end
        finish_resp();
        do_req(1'b0, 3'b100, 12'h013, 32'd0);
        checks++; if (last_rdata !== 32'h00000080) begin failures++; $display("FAIL lbu_rdata actual=%h required=00000080", last_rdata); end
        finish_resp();
        // Word 4 is now 0x80ADBEEF
        do_req(1'b0, 3'b001, 12'h012, 32'd0);
        checks++; if (last_rdata !== 32'hFFFF80AD) begin failures++; $display("FAIL lh_rdata actual=%h required=ffff80ad", last_rdata); end
        finish_resp();
        do_req(1'b0, 3'b101, 12'h012, 32'd0);
        checks++; if (last_rdata !== 32'h000080AD) begin failures++; $display("FAIL lhu_rdata actual=%h required=000080ad", last_rdata); end
        finish_resp();
    endtask

    task automatic test_split;
        int b0, bb;
        b0 = beat_total; bb = beat_total_b;
        do_req(1'b1, 3'b010, 12'h0FE, 32'h11223344);
        checks++; if (last_lat != 4 || last_err !== 1'b0) begin failures++; $display("FAIL ssw_latency actual=%0d/%b required=4/0", last_lat, last_err); end
        checks++; if (beat_total - b0 != 2) begin failures++; $display("FAIL ssw_beats actual=%0d required=2", beat_total - b0); end
        checks++; if ({log_be[b0 % 64], log_addr[b0 % 64], log_wd[b0 % 64]} !== {4'b1100, 10'h03F, 32'h33440000})
            begin failures++; $display("FAIL ssw_beat0 actual=%b/%h/%h required=1100/03f/33440000", log_be[b0 % 64], log_addr[b0 % 64], log_wd[b0 % 64]); end
        checks++; if ({log_be[(b0 + 1) % 64], log_addr[(b0 + 1) % 64], log_wd[(b0 + 1) % 64]} !== {4'b0011, 10'h040, 32'h00001122})
            begin failures++; $display("FAIL ssw_beat1 actual=%b/%h/%h required=0011/040/00001122", log_be[(b0 + 1) % 64], log_addr[(b0 + 1) % 64], log_wd[(b0 + 1) % 64]); end
        checks++; if (last_err_b !== 1'b1 || beat_total_b != bb) begin failures++; $display("FAIL ssw_nomis actual=%b/%0d required=1/0", last_err_b, beat_total_b - bb); end
        finish_resp();
        b0 = beat_total; bb = beat_total_b;
        do_req(1'b0, 3'b010, 12'h0FE, 32'd0);
        checks++; if (last_lat != 5) begin failures++; $display("FAIL slw_latency actual=%0d required=5", last_lat); end
        checks++; if (last_rdata !== 32'h11223344 || last_err !== 1'b0) begin failures++; $display("FAIL slw_rdata actual=%h/%b required=11223344/0", last_rdata, last_err); end
        checks++; if ({log_addr[b0 % 64], log_addr[(b0 + 1) % 64], log_we[b0 % 64], log_we[(b0 + 1) % 64]} !== {10'h03F, 10'h040, 2'b00})
            begin failures++; $display("FAIL slw_beats actual=%h/%h required=03f/040", log_addr[b0 % 64], log_addr[(b0 + 1) % 64]); end
        checks++; if (last_err_b !== 1'b1 || last_rdata_b !== 32'd0 || beat_total_b != bb)
            begin failures++; $display("FAIL slw_nomis actual=%b/%h/%0d required=1/0/0", last_err_b, last_rdata_b, beat_total_b - bb); end
        finish_resp();
    endtask

    task automatic test_gpio;
        int b0;
        b0 = beat_total;
        do_req(1'b1, 3'b010, 12'hEF0, 32'hA5A5A5A5);
        checks++; if (last_lat != 2 || last_err !== 1'b0) begin failures++; $display("FAIL gsw_latency actual=%0d/%b required=2/0", last_lat, last_err); end
        checks++; if (gpio_out !== 64'h00000000_A5A5A5A5) begin failures++; $display("FAIL gsw_out actual=%h required=00000000a5a5a5a5", gpio_out); end
        finish_resp();
        gpio_in = {32'h0, 32'h0000005A};
        repeat (3) @(posedge clk);
        do_req(1'b0, 3'b010, 12'hEF8, 32'd0);
        checks++; if (last_rdata !== 32'h0000005A || last_lat != 2) begin failures++; $display("FAIL glw_in actual=%h/%0d required=0000005a/2", last_rdata, last_lat); end
        finish_resp();
        do_req(1'b0, 3'b010, 12'hEF0, 32'd0);
        checks++; if (last_rdata !== 32'hA5A5A5A5) begin failures++; $display("FAIL glw_out actual=%h required=a5a5a5a5", last_rdata); end
        finish_resp();
        do_req(1'b1, 3'b001, 12'hEF0, 32'h00001234);
        checks++; if (last_err !== 1'b1 || gpio_out !== 64'h00000000_A5A5A5A5) begin failures++; $display("FAIL gsh_err actual=%b/%h required=1/00000000a5a5a5a5", last_err, gpio_out); end
        finish_resp();
        do_req(1'b1, 3'b010, 12'hEF8, 32'h77777777);
        checks++; if (last_err !== 1'b0 || gpio_out !== 64'h00000000_A5A5A5A5) begin failures++; $display("FAIL gsw_in_ignored actual=%b/%h required=0/00000000a5a5a5a5", last_err, gpio_out); end
        finish_resp();
        do_req(1'b0, 3'b010, 12'hEF6, 32'd0);
        checks++; if (last_err !== 1'b1 || last_rdata !== 32'd0) begin failures++; $display("FAIL glw_off actual=%b/%h required=1/0", last_err, last_rdata); end
        finish_resp();
        checks++; if (beat_total != b0) begin failures++; $display("FAIL gpio_no_ram actual=%0d required=0", beat_total - b0); end
    endtask

    task automatic test_boundary;
        int b0;
        b0 = beat_total;
        do_req(1'b0, 3'b010, 12'hFFE, 32'd0);
        checks++; if (last_err !== 1'b1 || last_lat != 2 || beat_total != b0) begin failures++; $display("FAIL oob_lw actual=%b/%0d/%0d required=1/2/0", last_err, last_lat, beat_total - b0); end
        finish_resp();
        do_req(1'b0, 3'b001, 12'hFFF, 32'd0);
        checks++; if (last_err !== 1'b1) begin failures++; $display("FAIL oob_lh actual=%b required=1", last_err); end
        finish_resp();
        b0 = beat_total;
        do_req(1'b1, 3'b010, 12'hFFC, 32'hCAFEF00D);
        checks++; if (last_err !== 1'b0 || log_addr[b0 % 64] !== 10'h3FF) begin failures++; $display("FAIL top_sw actual=%b/%h required=0/3ff", last_err, log_addr[b0 % 64]); end
        finish_resp();
        do_req(1'b0, 3'b010, 12'hFFC, 32'd0);
        checks++; if (last_rdata !== 32'hCAFEF00D) begin failures++; $display("FAIL top_lw actual=%h required=cafef00d", last_rdata); end
        finish_resp();
    endtask

    task automatic test_resp_hold;
        int b0;
        do_req(1'b0, 3'b011, 12'h020, 32'd0);
        checks++; if (last_err !== 1'b1 || last_lat != 2) begin failures++; $display("FAIL f3_err actual=%b/%0d required=1/2", last_err, last_lat); end
        b0 = beat_total;
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 12'h100; req_wdata = 32'h12345678; req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'd0 || req_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold_cycle%0d actual=%b/%b/%h/%b required=1/1/0/0", c, resp_valid, resp_err, resp_rdata, req_ready);
            end
        end
        req_valid = 1'b0;
        finish_resp();
        checks++; if (resp_valid !== 1'b0 || beat_total != b0) begin failures++; $display("FAIL hold_release actual=%b/%0d required=0/0", resp_valid, beat_total - b0); end
    endtask

    task automatic test_reset_mid;
        int n;
        @(negedge clk);
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 12'h0FE; req_wdata = 32'd0; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;  // accept edge, now DECODE
        req_valid = 1'b0;
        @(posedge clk); #1;  // BEAT0
        @(posedge clk); #1;  // BEAT1
        checks++; if (mem_en !== 1'b1 || mem_waddr !== 10'h040) begin failures++; $display("FAIL mid_beat1 actual=%b/%h required=1/040", mem_en, mem_waddr); end
        reset_n = 1'b0;
        #1;
        checks++; if (mem_en !== 1'b0 || resp_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_outputs actual=%b/%b required=0/0", mem_en, resp_valid); end
        checks++; if (req_ready !== 1'b1 || gpio_out !== 64'd0) begin failures++; $display("FAIL mid_rst_state actual=%b/%h required=1/0", req_ready, gpio_out); end
        @(negedge clk);
        reset_n = 1'b1;
        do_req(1'b0, 3'b010, 12'h010, 32'd0);
        checks++; if (last_rdata !== 32'h80ADBEEF || last_lat != 4) begin failures++; $display("FAIL post_rst_lw actual=%h/%0d required=80adbeef/4", last_rdata, last_lat); end
        finish_resp();
    endtask

    initial begin
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = '0; req_wdata = 32'd0;
        resp_ready = 1'b0; gpio_in = 64'd0;
        test_reset();
        test_aligned_word();
        test_byte_half();
        test_split();
        test_gpio();
        test_boundary();
        test_resp_hold();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
